tlu_trigger_transmitter_fsm: RTL and testbench

TLU-side transmitter for the TLU handshake/trigger-number protocol. Raises the trigger line on request, waits for the DUT to raise BUSY, then shifts the current 32-bit trigger number out serially on the trigger line, one bit per DUT-generated TLU clock edge. It then waits for BUSY to drop and increments the trigger counter. It sits in the TLU-emulator/test-stand firmware, facing the DUT-side serial-to-parallel receiver across the LVDS TLU link.

---
 rtl/tlu_pkg.sv | 37 +++
 rtl/tlu_edge_detect.sv | 22 ++
 rtl/tlu_trigger_transmitter_fsm.sv | 174 +++++++++++++++++
 tb/tb_tlu_trigger_transmitter_fsm.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger transmitter: FSM encoding, bit-count decode and load ordering.
package tlu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_TRIGGER,
    WAIT_CLOCK,
    SHIFT,
    WAIT_BUSY_LOW,
    DONE
  } tlu_state_t;

  localparam int         TRIGGER_WIDTH          = 32;
  localparam logic [7:0] DEFAULT_TIMEOUT_CYCLES = 8'd100;

  // A zero bit-count field selects the full 32-bit trigger number.
  function automatic logic [5:0] decode_bits(input logic [4:0] field);
    return (field == 5'd0) ? 6'd32 : {1'b0, field};
  endfunction

  // The shift register always emits bit 31 first, so both orders are
  // pre-arranged here; bits above N are masked so the tail shifts out zeros.
  function automatic logic [31:0] load_shift(input logic [31:0] num,
                                             input logic [5:0]  nbits,
                                             input logic        msb_first);
    logic [31:0] mask;
    logic [31:0] masked;
    logic [31:0] rev;
    mask   = (nbits >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    masked = num & mask;
    for (int i = 0; i < 32; i++) begin
      rev[i] = masked[31-i];
    end
    return msb_first ? (masked << (6'd32 - nbits)) : rev;
  endfunction

endpackage

// File: rtl/tlu_edge_detect.sv
// Registered 0->1 detector; the pulse trails the input edge by one CLK cycle.
// No backpressure: a single-cycle pulse per rising edge, never held.
module tlu_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sig_d <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sig_d <= sig;
      rise  <= sig & ~sig_d;
    end
  end

endmodule

// File: rtl/tlu_trigger_transmitter_fsm.sv
// TLU-side trigger/handshake transmitter: raise trigger, wait BUSY, serialise counter on TLU_CLOCK rises.
// Latency: trigger 1 cycle after request, data bit 2 cycles after TLU_CLOCK rise; requests while busy are dropped.
module tlu_trigger_transmitter_fsm
  import tlu_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     TRIGGER_REQUEST,
  input  logic [4:0]               TRIGGER_NUMBER_BITS,
  input  logic                     DATA_MSB_FIRST,
  input  logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES,
  input  logic                     COUNTER_RESET,
  input  logic                     TLU_BUSY,
  input  logic                     TLU_CLOCK,
  output logic                     TLU_TRIGGER,
  output logic [31:0]              TRIGGER_NUMBER,
  output logic                     TRIGGER_ACCEPTED_FLAG,
  output logic                     TRIGGER_DROPPED_FLAG,
  output logic                     TIMEOUT_FLAG
);

  tlu_state_t state_q, state_n;

  logic                     clk_rise;
  logic [31:0]              trig_cnt_q, trig_cnt_n;
  logic [31:0]              shift_q, shift_n;
  logic [5:0]               bit_cnt_q, bit_cnt_n;
  logic [5:0]               nbits_q, nbits_n;
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_n, to_cnt_inc;
  logic                     trig_n, acc_n, drop_n, to_n;

  tlu_edge_detect u_clk_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .sig   (TLU_CLOCK),
    .rise  (clk_rise)
  );

  assign TRIGGER_NUMBER = trig_cnt_q;
  assign to_cnt_inc     = to_cnt_q + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt_q;
    nbits_n   = nbits_q;
    to_cnt_n  = to_cnt_q;
    trig_n    = 1'b0;
    acc_n     = 1'b0;
    drop_n    = 1'b0;
    to_n      = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_n = '0;
        if (TRIGGER_REQUEST) begin
          if (!TLU_BUSY) begin
            state_n   = ASSERT_TRIGGER;
            trig_n    = 1'b1;
            nbits_n   = decode_bits(TRIGGER_NUMBER_BITS);
            bit_cnt_n = '0;
          end else begin
            drop_n = 1'b1;
          end
        end
      end

      ASSERT_TRIGGER: begin
        trig_n   = 1'b1;
        to_cnt_n = to_cnt_inc;
        // BUSY acknowledge wins over a timeout expiring in the same cycle.
        if (TLU_BUSY) begin
          shift_n = load_shift(trig_cnt_q, nbits_q, DATA_MSB_FIRST);
          state_n = WAIT_CLOCK;
          trig_n  = 1'b0;
        end else if ((TIMEOUT_CYCLES != '0) && (to_cnt_inc == TIMEOUT_CYCLES)) begin
          state_n = IDLE;
          trig_n  = 1'b0;
          to_n    = 1'b1;
        end
      end

      WAIT_CLOCK: begin
        if (clk_rise) begin
          trig_n    = shift_q[31];
          shift_n   = shift_q << 1;
          bit_cnt_n = 6'd1;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        trig_n = TLU_TRIGGER;
        if (!TLU_BUSY) begin
          state_n = DONE;
          trig_n  = 1'b0;
        end else if (clk_rise) begin
          if (bit_cnt_q == nbits_q) begin
            trig_n  = 1'b0;
            state_n = WAIT_BUSY_LOW;
          end else begin
            trig_n    = shift_q[31];
            shift_n   = shift_q << 1;
            bit_cnt_n = bit_cnt_q + 6'd1;
          end
        end
      end

      WAIT_BUSY_LOW: begin
        if (!TLU_BUSY) begin
          state_n = DONE;
        end
      end

      DONE: begin
        acc_n   = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (TRIGGER_REQUEST && (state_q != IDLE)) begin
      drop_n = 1'b1;
    end

    // The transmitted value was latched at load time, so a clear here only
    // affects the counter, never the bits already in flight.
    if (COUNTER_RESET) begin
      trig_cnt_n = '0;
    end else if (state_q == DONE) begin
      trig_cnt_n = trig_cnt_q + 32'd1;
    end else begin
      trig_cnt_n = trig_cnt_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      trig_cnt_q            <= '0;
      shift_q               <= '0;
      bit_cnt_q             <= '0;
      nbits_q               <= '0;
      to_cnt_q              <= '0;
      TLU_TRIGGER           <= 1'b0;
      TRIGGER_ACCEPTED_FLAG <= 1'b0;
      TRIGGER_DROPPED_FLAG  <= 1'b0;
      TIMEOUT_FLAG          <= 1'b0;
    end else begin
      trig_cnt_q            <= trig_cnt_n;
      shift_q               <= shift_n;
      bit_cnt_q             <= bit_cnt_n;
      nbits_q               <= nbits_n;
      to_cnt_q              <= to_cnt_n;
      TLU_TRIGGER           <= trig_n;
      TRIGGER_ACCEPTED_FLAG <= acc_n;
      TRIGGER_DROPPED_FLAG  <= drop_n;
      TIMEOUT_FLAG          <= to_n;
    end
  end

endmodule

// File: tb/tb_tlu_trigger_transmitter_fsm.sv
// Randomised bench: per-transaction timelines are planned from protocol rules and compared every cycle.
module tb_tlu_trigger_transmitter_fsm;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TRIGGER_REQUEST;
  logic [4:0]  TRIGGER_NUMBER_BITS;
  logic        DATA_MSB_FIRST;
  logic [7:0]  TIMEOUT_CYCLES;
  logic        COUNTER_RESET;
  logic        TLU_BUSY;
  logic        TLU_CLOCK;
  logic        TLU_TRIGGER;
  logic [31:0] TRIGGER_NUMBER;
  logic        TRIGGER_ACCEPTED_FLAG;
  logic        TRIGGER_DROPPED_FLAG;
  logic        TIMEOUT_FLAG;

  tlu_trigger_transmitter_fsm #(.TIMEOUT_WIDTH(8)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .TRIGGER_REQUEST       (TRIGGER_REQUEST),
    .TRIGGER_NUMBER_BITS   (TRIGGER_NUMBER_BITS),
    .DATA_MSB_FIRST        (DATA_MSB_FIRST),
    .TIMEOUT_CYCLES        (TIMEOUT_CYCLES),
    .COUNTER_RESET         (COUNTER_RESET),
    .TLU_BUSY              (TLU_BUSY),
    .TLU_CLOCK             (TLU_CLOCK),
    .TLU_TRIGGER           (TLU_TRIGGER),
    .TRIGGER_NUMBER        (TRIGGER_NUMBER),
    .TRIGGER_ACCEPTED_FLAG (TRIGGER_ACCEPTED_FLAG),
    .TRIGGER_DROPPED_FLAG  (TRIGGER_DROPPED_FLAG),
    .TIMEOUT_FLAG          (TIMEOUT_FLAG)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  logic        nx_trig, nx_acc, nx_drop, nx_to;
  logic [31:0] nx_num;
  logic [31:0] model_cnt;
  logic [31:0] force_val;

  // Planned per-cycle stimulus and expected outputs for one transaction.
  bit          a_req [0:1023];
  bit          a_busy[0:1023];
  bit          a_tclk[0:1023];
  bit          a_cr  [0:1023];
  bit          e_trig[0:1023];
  bit          e_acc [0:1023];
  bit          e_drop[0:1023];
  bit          e_to  [0:1023];
  logic [31:0] e_num [0:1023];
  int          cap_k [0:1023];

  logic [63:0] seq;
  int          acc_seen, drop_seen, to_seen, trig_hi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("trigger_line",   {63'd0, TLU_TRIGGER},           {63'd0, nx_trig});
      check("accepted_flag",  {63'd0, TRIGGER_ACCEPTED_FLAG}, {63'd0, nx_acc});
      check("dropped_flag",   {63'd0, TRIGGER_DROPPED_FLAG},  {63'd0, nx_drop});
      check("timeout_flag",   {63'd0, TIMEOUT_FLAG},          {63'd0, nx_to});
      check("trigger_number", {32'd0, TRIGGER_NUMBER},        {32'd0, nx_num});
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic set_counter(input logic [31:0] v);
    force_val = v;
    force dut.trig_cnt_q = force_val;
    model_cnt = v;
    nx_num    = v;
    step();
    release dut.trig_cnt_q;
  endtask

  task automatic run_txn(input logic [4:0] nf, input bit msb, input int d, input logic [7:0] tmo,
                         input bit drop_idle, input bit drop_shift, input bit cr_done, input int extra);
    int          n, r, L, b, j, hi, lo;
    int          rises[$];
    logic [31:0] val, fin;
    bit          timed_out;
    n = (nf == 5'd0) ? 32 : int'(nf);
    for (int i = 0; i < 1024; i++) begin
      a_req[i] = 0; a_busy[i] = 0; a_tclk[i] = 0; a_cr[i] = 0;
      e_trig[i] = 0; e_acc[i] = 0; e_drop[i] = 0; e_to[i] = 0;
      e_num[i] = model_cnt; cap_k[i] = 0;
    end
    r         = 3;
    val       = model_cnt;
    timed_out = (tmo != 8'd0) && (d > int'(tmo));
    if (drop_idle) begin
      a_req[1] = 1; a_busy[1] = 1; e_drop[1] = 1;
    end
    a_req[r] = 1;
    if (timed_out) begin
      for (int i = r; i < r + int'(tmo); i++) e_trig[i] = 1;
      e_to[r + int'(tmo)] = 1;
      L = r + int'(tmo) + 3;
    end else begin
      for (int i = r; i < r + d; i++) e_trig[i] = 1;
      j = r + d + 1 + int'($urandom_range(0, 2));
      for (int k = 0; k < n + 1 + extra; k++) begin
        hi = int'($urandom_range(1, 3));
        lo = int'($urandom_range(1, 3));
        for (int i = 0; i < hi; i++) a_tclk[j+i] = 1;
        j += hi + lo;
      end
      b = j + int'($urandom_range(0, 2));
      for (int i = r + d; i < b; i++) a_busy[i] = 1;
      for (int i = r + d + 1; i < b; i++)
        if (a_tclk[i] && !a_tclk[i-1] && rises.size() < n + 1) rises.push_back(i);
      // Bit k shows two cycles after the k-th TLU_CLOCK rise is sampled and holds until the next.
      for (int k = 1; k <= n; k++)
        for (int i = rises[k-1] + 1; i <= rises[k]; i++)
          e_trig[i] = msb ? val[n-k] : val[k-1];
      for (int k = 1; k <= n + 1; k++) cap_k[rises[k-1] + 1] = k;
      if (drop_shift) begin
        a_req[rises[1]] = 1; e_drop[rises[1]] = 1;
      end
      fin = cr_done ? 32'd0 : val + 32'd1;
      if (cr_done) a_cr[b+1] = 1;
      e_acc[b+1] = 1;
      for (int i = b + 1; i < 1024; i++) e_num[i] = fin;
      model_cnt = fin;
      L = b + 4;
    end
    TRIGGER_NUMBER_BITS = nf;
    DATA_MSB_FIRST      = msb;
    TIMEOUT_CYCLES      = tmo;
    seq = '0; acc_seen = 0; drop_seen = 0; to_seen = 0; trig_hi = 0;
    for (int i = 0; i < L; i++) begin
      TRIGGER_REQUEST = a_req[i];
      TLU_BUSY        = a_busy[i];
      TLU_CLOCK       = a_tclk[i];
      COUNTER_RESET   = a_cr[i];
      nx_trig = e_trig[i]; nx_acc = e_acc[i]; nx_drop = e_drop[i]; nx_to = e_to[i]; nx_num = e_num[i];
      step();
      if (cap_k[i] != 0) seq[cap_k[i]-1] = TLU_TRIGGER;
      acc_seen  += int'(TRIGGER_ACCEPTED_FLAG);
      drop_seen += int'(TRIGGER_DROPPED_FLAG);
      to_seen   += int'(TIMEOUT_FLAG);
      trig_hi   += int'(TLU_TRIGGER);
    end
    TRIGGER_REQUEST = 0; TLU_BUSY = 0; TLU_CLOCK = 0; COUNTER_RESET = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    TRIGGER_REQUEST = 0; TRIGGER_NUMBER_BITS = 0; DATA_MSB_FIRST = 1; TIMEOUT_CYCLES = 0;
    COUNTER_RESET = 0; TLU_BUSY = 0; TLU_CLOCK = 0;
    nx_trig = 0; nx_acc = 0; nx_drop = 0; nx_to = 0; nx_num = 0; model_cnt = 0;
    #2;
    check("reset_trigger",  {63'd0, TLU_TRIGGER},           64'd0);
    check("reset_number",   {32'd0, TRIGGER_NUMBER},        64'd0);
    check("reset_accepted", {63'd0, TRIGGER_ACCEPTED_FLAG}, 64'd0);
    check("reset_dropped",  {63'd0, TRIGGER_DROPPED_FLAG},  64'd0);
    check("reset_timeout",  {63'd0, TIMEOUT_FLAG},          64'd0);
    @(negedge CLK); #1;
    RESET  = 1'b0;
    chk_en = 1'b1;
    step();

    set_counter(32'h0000_00A5);
    run_txn(5'd8, 1'b1, 3, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    check("basic_bits",     seq,                     64'h0A5);
    check("basic_number",   {32'd0, TRIGGER_NUMBER}, 64'h0A6);
    check("basic_accepted", 64'(acc_seen),           64'd1);

    set_counter(32'h0000_0003);
    run_txn(5'd4, 1'b0, 2, 8'd0, 1'b0, 1'b0, 1'b0, 1);
    check("lsb_bits", seq, 64'h03);

    set_counter(32'h8000_0001);
    run_txn(5'd0, 1'b1, 1, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    check("n32_bits",   seq,                     64'h0_8000_0001);
    check("n32_number", {32'd0, TRIGGER_NUMBER}, 64'h8000_0002);

    set_counter(32'h0000_0055);
    run_txn(5'd8, 1'b1, 50, 8'd10, 1'b0, 1'b0, 1'b0, 0);
    check("timeout_high_cycles", 64'(trig_hi),            64'd10);
    check("timeout_pulses",      64'(to_seen),            64'd1);
    check("timeout_number",      {32'd0, TRIGGER_NUMBER}, 64'h55);

    run_txn(5'd2, 1'b1, 500, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    check("slow_busy_accepted", 64'(acc_seen),           64'd1);
    check("slow_busy_number",   {32'd0, TRIGGER_NUMBER}, 64'h56);

    run_txn(5'd5, 1'b1, 2, 8'd0, 1'b1, 1'b1, 1'b0, 0);
    check("dropped_pulses",   64'(drop_seen), 64'd2);
    check("dropped_accepted", 64'(acc_seen),  64'd1);

    set_counter(32'hFFFF_FFFF);
    run_txn(5'd4, 1'b1, 1, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    check("wrap_bits",   seq,                     64'h0F);
    check("wrap_number", {32'd0, TRIGGER_NUMBER}, 64'd0);

    set_counter(32'h0000_1234);
    run_txn(5'd3, 1'b0, 2, 8'd0, 1'b0, 1'b0, 1'b1, 0);
    check("clear_in_done", {32'd0, TRIGGER_NUMBER}, 64'd0);

    // Abort a transaction after five bits with an asynchronous reset.
    set_counter(32'h0000_0077);
    chk_en = 1'b0;
    TRIGGER_NUMBER_BITS = 5'd8; DATA_MSB_FIRST = 1'b1; TIMEOUT_CYCLES = 8'd0;
    TRIGGER_REQUEST = 1; step(); TRIGGER_REQUEST = 0;
    TLU_BUSY = 1; step(); step();
    for (int k = 0; k < 5; k++) begin
      TLU_CLOCK = 1; step();
      TLU_CLOCK = 0; step();
    end
    step();
    RESET = 1'b1;
    #1;
    check("abort_trigger",  {63'd0, TLU_TRIGGER},           64'd0);
    check("abort_number",   {32'd0, TRIGGER_NUMBER},        64'd0);
    check("abort_accepted", {63'd0, TRIGGER_ACCEPTED_FLAG}, 64'd0);
    check("abort_dropped",  {63'd0, TRIGGER_DROPPED_FLAG},  64'd0);
    check("abort_timeout",  {63'd0, TIMEOUT_FLAG},          64'd0);
    TLU_BUSY = 0;
    step();
    RESET = 1'b0;
    model_cnt = 0;
    nx_trig = 0; nx_acc = 0; nx_drop = 0; nx_to = 0; nx_num = 0;
    chk_en = 1'b1;
    step();
    run_txn(5'd8, 1'b1, 2, 8'd0, 1'b0, 1'b0, 1'b0, 0);
    check("post_abort_bits",   seq,                     64'h0);
    check("post_abort_number", {32'd0, TRIGGER_NUMBER}, 64'd1);

    for (int t = 0; t < 30; t++) begin
      int          d, sel;
      logic [7:0]  tmo;
      logic [4:0]  nf;
      set_counter($urandom);
      nf  = 5'($urandom_range(0, 31));
      d   = int'($urandom_range(1, 6));
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      tmo = 8'd0;
      else if (sel == 1) tmo = tlu_pkg::DEFAULT_TIMEOUT_CYCLES;
      else begin
        tmo = 8'($urandom_range(1, 8));
        if (d == int'(tmo)) d = d + 1;
      end
      run_txn(nf, 1'($urandom_range(0, 1)), d, tmo, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
